// File: rtl/ahb_gpio_pkg.sv
// Shared register map, interrupt type/polarity encodings and the per-pin
// interrupt event rule for the AHB-Lite GPIO block.
package ahb_gpio_pkg;

    localparam logic [7:0] OFF_DATA_OUT   = 8'h00;
    localparam logic [7:0] OFF_DIR        = 8'h04;
    localparam logic [7:0] OFF_DATA_IN    = 8'h08;
    localparam logic [7:0] OFF_INT_EN     = 8'h0C;
    localparam logic [7:0] OFF_INT_TYPE   = 8'h10;
    localparam logic [7:0] OFF_INT_POL    = 8'h14;
    localparam logic [7:0] OFF_INT_STATUS = 8'h18;
    localparam logic [7:0] OFF_OUT_SET    = 8'h1C;
    localparam logic [7:0] OFF_OUT_CLR    = 8'h20;

    typedef enum logic {INT_LEVEL = 1'b0, INT_EDGE = 1'b1} int_type_e;
    typedef enum logic {POL_LOW = 1'b0, POL_HIGH = 1'b1} int_pol_e;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [5:0] addr;
    } addr_phase_t;

    // Edge mode looks at the synchronized value against its one-cycle-old copy;
    // level mode looks only at the synchronized value.
    function automatic logic pin_event(input logic itype, input logic pol,
                                       input logic cur, input logic prev);
        if (itype == INT_EDGE)
            return (pol == POL_HIGH) ? (cur & ~prev) : (~cur & prev);
        else
            return (pol == POL_HIGH) ? cur : ~cur;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer chain for asynchronous pad inputs.
module gpio_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // NOTE: clocked state is written with <= so every stage samples the value
    // its neighbour held before this edge; blocking '=' would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ahb_gpio_n.sv
// AHB-Lite GPIO slave: zero-wait register file, per-pin direction, and
// edge/level interrupts on synchronized pad inputs.
module ahb_gpio_n
    import ahb_gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    input  logic [WIDTH-1:0] IO_IN,
    output logic [WIDTH-1:0] IO_OUT,
    output logic [WIDTH-1:0] IO_OP_EN,
    output logic             IRQ
);

    addr_phase_t      ap;
    logic [7:0]       off;
    logic             wr;
    logic [WIDTH-1:0] wdata, w1c, rdata, evt;
    logic [WIDTH-1:0] data_out, dir, int_en, int_type, int_pol, int_status;
    logic [WIDTH-1:0] sync_q, prev_q;
    logic             unused_ok;

    // Only full-word accesses to byte offsets 0x00..0xFC are meaningful.
    assign unused_ok = ^{HSIZE, HADDR, HWDATA};

    assign off   = {ap.addr, 2'b00};
    assign wr    = ap.valid & ap.write;
    assign wdata = HWDATA[WIDTH-1:0];
    assign w1c   = (wr && off == OFF_INT_STATUS) ? wdata : '0;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (IO_IN),
        .q   (sync_q)
    );

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        evt = '0;
        for (int i = 0; i < WIDTH; i++)
            evt[i] = pin_event(int_type[i], int_pol[i], sync_q[i], prev_q[i]);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ap         <= '0;
            prev_q     <= '0;
            data_out   <= '0;
            dir        <= '0;
            int_en     <= '0;
            int_type   <= '0;
            int_pol    <= '0;
            int_status <= '0;
        end else begin
            if (HREADY) begin
                ap.valid <= HSEL & HTRANS[1];
                ap.write <= HWRITE;
                ap.addr  <= HADDR[7:2];
            end
            prev_q <= sync_q;
            // A new event overrides a simultaneous W1C, so a held level re-asserts.
            int_status <= (int_status & ~w1c) | evt;
            if (wr) begin
                case (off)
                    OFF_DATA_OUT: data_out <= wdata;
                    OFF_DIR:      dir      <= wdata;
                    OFF_INT_EN:   int_en   <= wdata;
                    OFF_INT_TYPE: int_type <= wdata;
                    OFF_INT_POL:  int_pol  <= wdata;
                    OFF_OUT_SET:  data_out <= data_out | wdata;
                    OFF_OUT_CLR:  data_out <= data_out & ~wdata;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ap.valid && !ap.write) begin
            case (off)
                OFF_DATA_OUT:   rdata = data_out;
                OFF_DIR:        rdata = dir;
                OFF_DATA_IN:    rdata = sync_q;
                OFF_INT_EN:     rdata = int_en;
                OFF_INT_TYPE:   rdata = int_type;
                OFF_INT_POL:    rdata = int_pol;
                OFF_INT_STATUS: rdata = int_status;
                default:        rdata = '0;
            endcase
        end
    end

    assign HRDATA    = 32'(rdata);
    assign HREADYOUT = 1'b1;
    assign IO_OUT    = data_out;
    assign IO_OP_EN  = dir;
    assign IRQ       = |(int_status & int_en);

endmodule

// File: tb/tb_ahb_gpio_n.sv
// Self-checking bench for ahb_gpio_n: directed scenarios plus randomized bus and
// pad traffic, checked every cycle against a behavioural register/pin model.
module tb_ahb_gpio_n;

    localparam int          W    = 16;
    localparam int          S    = 2;
    localparam logic [31:0] MASK = 32'h0000_FFFF;

    localparam logic [7:0] A_OUT = 8'h00, A_DIR = 8'h04, A_IN  = 8'h08, A_EN  = 8'h0C;
    localparam logic [7:0] A_TYP = 8'h10, A_POL = 8'h14, A_STA = 8'h18, A_SET = 8'h1C;
    localparam logic [7:0] A_CLR = 8'h20;

    logic        CLK = 1'b0;
    logic        RESET, HSEL, HSEL8, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, HREADYOUT8, IRQ, IRQ8;
    logic [31:0] HRDATA, HRDATA8;
    logic [W-1:0] IO_IN, IO_OUT, IO_OP_EN;
    logic [7:0]  IO_OUT8, IO_OP_EN8;

    int n_vec = 0;
    int n_err = 0;
    bit tgt8  = 1'b0;

    // Reference model state (full 32-bit words, upper bits kept at zero).
    logic [31:0] m_out, m_dir, m_en, m_type, m_pol, m_stat;
    logic [31:0] hist[$];          // pad samples per edge, newest first
    logic        dp_valid, dp_write;
    logic [7:0]  dp_addr;

    always #5 CLK = ~CLK;

    ahb_gpio_n #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .IO_IN(IO_IN), .IO_OUT(IO_OUT),
        .IO_OP_EN(IO_OP_EN), .IRQ(IRQ)
    );

    ahb_gpio_n #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL8), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT8), .HRDATA(HRDATA8), .IO_IN(IO_IN[7:0]), .IO_OUT(IO_OUT8),
        .IO_OP_EN(IO_OP_EN8), .IRQ(IRQ8)
    );

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_OUT:   return m_out;
            A_DIR:   return m_dir;
            A_IN:    return hist[S-1];
            A_EN:    return m_en;
            A_TYP:   return m_type;
            A_POL:   return m_pol;
            A_STA:   return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one rising edge, take the edge, then compare
    // the main DUT's visible outputs against the model.
    task automatic tick();
        logic [31:0] ev, wd, clr;
        ev = '0;
        if (RESET) begin
            {m_out, m_dir, m_en, m_type, m_pol, m_stat} = '0;
            hist.delete();
            repeat (S + 1) hist.push_front(32'h0);
            dp_valid = 1'b0;
            dp_write = 1'b0;
            dp_addr  = 8'h0;
        end else begin
            for (int i = 0; i < W; i++) begin
                bit cur, old;
                cur = hist[S-1][i];
                old = hist[S][i];
                if (m_type[i]) ev[i] = m_pol[i] ? (cur && !old) : (!cur && old);
                else           ev[i] = m_pol[i] ? cur : !cur;
            end
            wd  = HWDATA & MASK;
            clr = '0;
            if (dp_valid && dp_write) begin
                case (dp_addr)
                    A_OUT:   m_out  = wd;
                    A_DIR:   m_dir  = wd;
                    A_EN:    m_en   = wd;
                    A_TYP:   m_type = wd;
                    A_POL:   m_pol  = wd;
                    A_STA:   clr    = wd;
                    A_SET:   m_out  = m_out | wd;
                    A_CLR:   m_out  = m_out & ~wd;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | ev;
            hist.push_front(32'(IO_IN) & MASK);
            void'(hist.pop_back());
            if (HREADY) begin
                dp_valid = HSEL && HTRANS[1];
                dp_write = HWRITE;
                dp_addr  = {HADDR[7:2], 2'b00};
            end
        end
        @(posedge CLK);
        #1;
        n_vec++;
        if (IO_OUT !== m_out[W-1:0]) begin
            n_err++;
            $display("FAIL io_out t=%0t got=%h exp=%h", $time, IO_OUT, m_out[W-1:0]);
        end
        n_vec++;
        if (IO_OP_EN !== m_dir[W-1:0]) begin
            n_err++;
            $display("FAIL io_op_en t=%0t got=%h exp=%h", $time, IO_OP_EN, m_dir[W-1:0]);
        end
        n_vec++;
        if (IRQ !== |(m_stat & m_en)) begin
            n_err++;
            $display("FAIL irq t=%0t got=%b exp=%b", $time, IRQ, |(m_stat & m_en));
        end
        if (dp_valid && !dp_write) begin
            n_vec++;
            if (HRDATA !== m_read(dp_addr)) begin
                n_err++;
                $display("FAIL hrdata addr=%h t=%0t got=%h exp=%h", dp_addr, $time, HRDATA,
                         m_read(dp_addr));
            end
        end
        n_vec++;
        if (HREADYOUT !== 1'b1) begin
            n_err++;
            $display("FAIL hreadyout t=%0t got=%b exp=1", $time, HREADYOUT);
        end
    endtask

    // One bus cycle: new address phase plus HWDATA for the transfer in data phase.
    task automatic step(input logic sel, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata);
        HSEL   = tgt8 ? 1'b0 : sel;
        HSEL8  = tgt8 ? sel : 1'b0;
        HWRITE = wr;
        HTRANS = sel ? 2'b10 : 2'b00;
        HADDR  = {24'h0, addr};
        HWDATA = wdata;
        tick();
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
        step(1'b1, 1'b1, addr, 32'h0);
        step(1'b0, 1'b0, 8'h0, data);
    endtask

    task automatic rd_reg(input logic [7:0] addr, output logic [31:0] data);
        step(1'b1, 1'b0, addr, 32'h0);
        data = tgt8 ? HRDATA8 : HRDATA;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        RESET = 1'b1;
        IO_IN = '0;
        idle(2);
        n_vec++;
        if ({IO_OUT, IO_OP_EN, IRQ} !== '0) begin
            n_err++;
            $display("FAIL reset_held got=%h/%h/%b exp=0/0/0", IO_OUT, IO_OP_EN, IRQ);
        end
        RESET = 1'b0;
        idle(S + 2);
        rd_reg(A_DIR, r);
        n_vec++;
        if (r !== 32'h0) begin n_err++; $display("FAIL reset_dir got=%h exp=0", r); end
        // Default level-low mode with pads at 0 latches every pin's status bit.
        rd_reg(A_STA, r);
        n_vec++;
        if (r !== 32'h0000_FFFF) begin
            n_err++;
            $display("FAIL reset_status got=%h exp=0000ffff", r);
        end
        n_vec++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    endtask

    task automatic test_dir_out();
        logic [31:0] r;
        wr_reg(A_DIR, 32'h0000_00A5);
        wr_reg(A_OUT, 32'h0000_00FF);
        n_vec++;
        if (IO_OP_EN !== 16'h00A5 || IO_OUT !== 16'h00FF) begin
            n_err++;
            $display("FAIL dir_out got=%h/%h exp=00a5/00ff", IO_OP_EN, IO_OUT);
        end
        rd_reg(A_DIR, r);
        n_vec++;
        if (r !== 32'h0000_00A5) begin n_err++; $display("FAIL dir_read got=%h exp=000000a5", r); end
    endtask

    task automatic test_set_clr();
        logic [31:0] r;
        wr_reg(A_OUT, 32'h0000_0F0F);
        wr_reg(A_SET, 32'h0000_00F0);
        wr_reg(A_CLR, 32'h0000_000F);
        rd_reg(A_OUT, r);
        n_vec++;
        if (r !== 32'h0000_0FF0) begin n_err++; $display("FAIL set_clr got=%h exp=00000ff0", r); end
        rd_reg(A_SET, r);
        n_vec++;
        if (r !== 32'h0) begin n_err++; $display("FAIL read_set got=%h exp=0", r); end
        rd_reg(A_CLR, r);
        n_vec++;
        if (r !== 32'h0) begin n_err++; $display("FAIL read_clr got=%h exp=0", r); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] r;
        IO_IN = '0;
        idle(S + 2);
        wr_reg(A_TYP, 32'h0000_FFFF);
        wr_reg(A_POL, 32'h0000_FFFF);
        wr_reg(A_STA, 32'h0000_FFFF);
        wr_reg(A_EN,  32'h0000_0008);
        IO_IN = 16'h0008;
        for (int k = 1; k <= S + 1; k++) begin
            idle(1);
            n_vec++;
            if (IRQ !== (k == S + 1)) begin
                n_err++;
                $display("FAIL edge_latency cycle=%0d got=%b exp=%b", k, IRQ, k == S + 1);
            end
        end
        rd_reg(A_STA, r);
        n_vec++;
        if (r !== 32'h0000_0008) begin n_err++; $display("FAIL edge_status got=%h exp=00000008", r); end
        wr_reg(A_STA, 32'h0000_0008);
        n_vec++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL edge_w1c_irq got=%b exp=0", IRQ); end
    endtask

    task automatic test_level();
        logic [31:0] r;
        IO_IN = 16'h0008;
        wr_reg(A_TYP, 32'h0000_FFFE);
        wr_reg(A_POL, 32'h0000_FFFE);
        wr_reg(A_STA, 32'h0000_0001);
        rd_reg(A_STA, r);
        n_vec++;
        if (r !== 32'h0000_0001) begin n_err++; $display("FAIL level_held got=%h exp=00000001", r); end
        IO_IN = 16'h0009;
        idle(S + 1);
        wr_reg(A_STA, 32'h0000_0001);
        rd_reg(A_STA, r);
        n_vec++;
        if (r !== 32'h0) begin n_err++; $display("FAIL level_release got=%h exp=0", r); end
    endtask

    task automatic test_set_wins();
        logic [31:0] r;
        IO_IN = 16'h0029;
        idle(1);
        idle(S - 2);
        step(1'b1, 1'b1, A_STA, 32'h0);
        step(1'b0, 1'b0, 8'h0, 32'h0000_0020);
        rd_reg(A_STA, r);
        n_vec++;
        if (r !== 32'h0000_0020) begin n_err++; $display("FAIL set_wins got=%h exp=00000020", r); end
        wr_reg(A_STA, 32'h0000_0020);
        rd_reg(A_STA, r);
        n_vec++;
        if (r !== 32'h0) begin n_err++; $display("FAIL w1c_after got=%h exp=0", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom & MASK;
        step(1'b1, 1'b1, A_EN, 32'h0);
        step(1'b1, 1'b0, A_EN, d);
        n_vec++;
        if (HRDATA !== d) begin n_err++; $display("FAIL b2b_read got=%h exp=%h", HRDATA, d); end
        step(1'b1, 1'b1, A_IN, 32'h0);
        step(1'b1, 1'b0, A_IN, 32'hFFFF_FFFF);
        n_vec++;
        if (HRDATA !== 32'h0000_0029) begin
            n_err++;
            $display("FAIL data_in_ro got=%h exp=00000029", HRDATA);
        end
        step(1'b1, 1'b1, 8'h40, 32'h0);
        step(1'b1, 1'b0, 8'h40, 32'hFFFF_FFFF);
        n_vec++;
        if (HRDATA !== 32'h0) begin n_err++; $display("FAIL unmapped got=%h exp=0", HRDATA); end
        wr_reg(A_EN, 32'h0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) IO_IN = W'($urandom);
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 63) << 2)
                                            : 8'($urandom_range(0, 8) << 2);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
        end
        idle(2);
    endtask

    task automatic test_width8();
        logic [31:0] r;
        tgt8 = 1'b1;
        wr_reg(A_OUT, 32'hFFFF_FFFF);
        n_vec++;
        if (IO_OUT8 !== 8'hFF) begin n_err++; $display("FAIL w8_io_out got=%h exp=ff", IO_OUT8); end
        rd_reg(A_OUT, r);
        n_vec++;
        if (r !== 32'h0000_00FF) begin n_err++; $display("FAIL w8_read got=%h exp=000000ff", r); end
        wr_reg(A_DIR, 32'h0000_003C);
        // Reset lands in the data phase of a DIR write.
        step(1'b1, 1'b1, A_DIR, 32'h0);
        RESET = 1'b1;
        step(1'b0, 1'b0, 8'h0, 32'h0000_0055);
        n_vec++;
        if ({IO_OUT8, IO_OP_EN8, IRQ8} !== '0) begin
            n_err++;
            $display("FAIL w8_reset_outs got=%h/%h/%b exp=0/0/0", IO_OUT8, IO_OP_EN8, IRQ8);
        end
        // Address phase captured while reset is held, data phase after release.
        step(1'b1, 1'b1, A_DIR, 32'h0);
        RESET = 1'b0;
        step(1'b0, 1'b0, 8'h0, 32'h0000_0055);
        idle(1);
        n_vec++;
        if ({IO_OUT8, IO_OP_EN8, IRQ8} !== '0) begin
            n_err++;
            $display("FAIL w8_after_reset got=%h/%h/%b exp=0/0/0", IO_OUT8, IO_OP_EN8, IRQ8);
        end
        rd_reg(A_DIR, r);
        n_vec++;
        if (r !== 32'h0) begin n_err++; $display("FAIL w8_discard got=%h exp=0", r); end
        tgt8 = 1'b0;
        idle(1);
    endtask

    initial begin
        RESET  = 1'b1;
        HSEL   = 1'b0;
        HSEL8  = 1'b0;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HTRANS = 2'b00;
        HSIZE  = 3'b010;
        HADDR  = '0;
        HWDATA = '0;
        IO_IN  = '0;
        test_reset();
        test_dir_out();
        test_set_clr();
        test_edge_irq();
        test_level();
        test_set_wins();
        test_back_to_back();
        test_random();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_gpio_n.md
AHB_GPIO_N -- requirements
Module: ahb_gpio_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of GPIO pins, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..3.
REQ-003 SHALL have port CLK, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have AHB-Lite slave inputs HSEL 1, HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA 32, HREADY 1.
REQ-006 SHALL have AHB-Lite slave outputs HREADYOUT 1 and HRDATA 32.
REQ-007 SHALL have port IO_IN, input, WIDTH, asynchronous pad inputs.
REQ-008 SHALL have port IO_OUT, output, WIDTH, pad output data.
REQ-009 SHALL have port IO_OP_EN, output, WIDTH, per-pin output enable (1 = drive).
REQ-010 SHALL have port IRQ, output, 1, combined interrupt.

Function
REQ-011 SHALL tie HREADYOUT to 1 (zero wait states, OKAY-only).
REQ-012 SHALL capture HADDR[7:2] and HWRITE in the address phase when HSEL & HREADY & HTRANS[1].
REQ-013 SHALL apply the write using HWDATA in the following data-phase cycle.
REQ-014 SHALL drive HRDATA combinationally from the captured address during the data phase.
REQ-015 SHALL map 0x00 DATA_OUT RW, 0x04 DIR RW, 0x08 DATA_IN RO, 0x0C INT_EN RW, 0x10 INT_TYPE RW (1 = edge, 0 = level), 0x14 INT_POL RW (1 = rising/high, 0 = falling/low), 0x18 INT_STATUS RW1C, 0x1C OUT_SET WO, 0x20 OUT_CLR WO.
REQ-016 SHALL OR HWDATA into DATA_OUT on an OUT_SET write and AND-NOT HWDATA out of DATA_OUT on an OUT_CLR write.
REQ-017 SHALL return 0 on reads of OUT_SET, OUT_CLR and unmapped offsets, and ignore writes to unmapped offsets and DATA_IN.
REQ-018 SHALL read bits [31:WIDTH] of every register as 0 and ignore them on writes.
REQ-019 SHALL drive IO_OUT = DATA_OUT and IO_OP_EN = DIR directly from the registers, 1 cycle after the write data phase.
REQ-020 SHALL pass IO_IN through SYNC_STAGES flops; DATA_IN SHALL equal the last synchronizer stage.
REQ-021 SHALL keep one extra flop per pin (prev) to detect edges; rise = sync & ~prev, fall = ~sync & prev.
REQ-022 SHALL compute the per-pin event as follows:
- edge mode: event = INT_POL ? rise : fall.
- level mode: event = INT_POL ? sync : ~sync.
REQ-023 SHALL set INT_STATUS[i] on event[i] regardless of INT_EN.
REQ-024 SHALL clear INT_STATUS[i] on a W1C write with bit i = 1.
REQ-025 SHALL give set priority when set and W1C coincide on the same bit; a level interrupt therefore stays set while its level persists.
REQ-026 SHALL drive IRQ = |(INT_STATUS & INT_EN) as a combinational output.
REQ-027 SHALL produce an edge-mode interrupt in INT_STATUS exactly SYNC_STAGES+1 cycles after IO_IN changes (input sampled at a clock edge).
REQ-028 SHALL process back-to-back transfers with no gap; a read to the address just written SHALL return the new value.

Reset
REQ-029 SHALL, on RESET, clear DATA_OUT, DIR, INT_EN, INT_TYPE, INT_POL, INT_STATUS, the synchronizer and prev flops, and the captured address-phase state.
REQ-030 SHALL hold IO_OUT = 0, IO_OP_EN = 0 and IRQ = 0 during and after reset until software writes.
REQ-031 SHALL discard a transfer whose address phase was captured when RESET asserts mid-transfer.

Structure
REQ-032 SHALL place register offset constants and the type encodings (INT_TYPE, INT_POL) in shared package ahb_gpio_pkg.
REQ-033 SHALL instantiate one sub-module, gpio_sync (WIDTH-wide, SYNC_STAGES-deep flop chain, synchronous reset).

Verification
REQ-034 SHALL cover: write 0x00A5 to DIR, then 0x00FF to DATA_OUT -> IO_OP_EN = 0x00A5, IO_OUT = 0x00FF; read DIR returns 0x000000A5.
REQ-035 SHALL cover: DATA_OUT = 0x0F0F, write 0x00F0 to OUT_SET, then 0x000F to OUT_CLR -> DATA_OUT = 0x0FF0; reads of 0x1C and 0x20 return 0.
REQ-036 SHALL cover: INT_EN[3] = 1, INT_TYPE[3] = 1, INT_POL[3] = 1, IO_IN[3] 0->1 -> INT_STATUS = 0x0008 after 3 cycles (SYNC_STAGES = 2), IRQ = 1; W1C 0x0008 -> IRQ = 0.
REQ-037 SHALL cover: level-low on pin 0 with IO_IN[0] held 0, W1C 0x0001 -> bit stays 1; release IO_IN[0] = 1, then W1C -> bit 0 = 0.
REQ-038 SHALL cover: a rising edge on pin 5 landing in the same cycle as its W1C -> INT_STATUS[5] = 1 (set wins).
REQ-039 SHALL cover: WIDTH = 8 build, write 0xFFFFFFFF to DATA_OUT -> read returns 0x000000FF; RESET mid-write -> all outputs 0 and the write is discarded.
